// File: rtl/cart_pkg.sv
// Shared cart command codes and the command-arbiter state type.
package cart_pkg;

  typedef logic [31:0] cmd_t;

  localparam cmd_t CMD_ON     = 32'h45BAFF00;
  localparam cmd_t CMD_OFF    = 32'h46B9FF00;
  localparam cmd_t CMD_STOP   = 32'h619EFF00;
  localparam cmd_t CMD_FWD    = 32'h18E7FF00;
  localparam cmd_t CMD_REV    = 32'h52ADFF00;
  localparam cmd_t CMD_SPD_UP = 32'h09F6FF00;
  localparam cmd_t CMD_SPD_DN = 32'h07F8FF00;
  localparam cmd_t CMD_LEFT   = 32'h08F7FF00;
  localparam cmd_t CMD_RIGHT  = 32'h5AA5FF00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } arb_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, async active-high reset to zero.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter sharing the control block's ready/command/ack handshake
// between command sources, with handshake timeout and stop-command watchdog.
module cmd_arbiter
  import cart_pkg::*;
#(
  parameter int unsigned clk_hz       = 25000000,
  parameter int unsigned sclk_hz      = 256,
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned TIMEOUT_SCLK = 4,
  parameter int unsigned WDOG_MS      = 500,
  parameter logic [31:0] STOP_CMD     = CMD_STOP
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_ready,
  input  logic [32*NUM_SRC-1:0]          src_command,
  output logic [NUM_SRC-1:0]             src_ack,
  output logic                           ctl_ready,
  output logic [31:0]                    ctl_command,
  input  logic                           ctl_ack,
  output logic [$clog2(NUM_SRC+1)-1:0]   grant_id,
  output logic                           busy,
  output logic                           timeout_err,
  output logic                           wdog_fired
);

  localparam int unsigned GW          = $clog2(NUM_SRC + 1);
  localparam int unsigned TIMEOUT_CYC = TIMEOUT_SCLK * clk_hz / sclk_hz;
  localparam int unsigned WDOG_CYC    = clk_hz / 1000 * WDOG_MS;
  localparam int unsigned TW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned WW          = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam bit          WDOG_EN     = (WDOG_CYC != 0);

  arb_state_t              state, state_n;
  logic                    ack_s;
  logic [TW-1:0]           tcnt, tcnt_n;
  logic [WW-1:0]           wcnt, wcnt_n;
  logic                    wdog_pend, wdog_pend_n;
  logic [GW-1:0]           rr_ptr, rr_ptr_n;
  logic [GW-1:0]           grant_id_n;
  logic [31:0]             ctl_command_n;
  logic                    ctl_ready_n, timeout_err_n, wdog_fired_n;
  logic [NUM_SRC-1:0]      src_ack_n, ack_vec;
  logic [NUM_SRC-1:0][31:0] src_cmd_a;
  logic [GW-1:0]           cand, pick_idx;
  logic                    pick_vld;
  logic                    tmo_hit, wdog_hit;

  assign src_cmd_a = src_command;
  assign tmo_hit   = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign wdog_hit  = (wcnt == WW'(WDOG_CYC - 1));

  sync_2ff #(.W(1)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ctl_ack),
    .q   (ack_s)
  );

  // First requesting source after rr_ptr, wrapping around.
  always_comb begin
    cand     = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      if (32'(rr_ptr) + k >= NUM_SRC) cand = GW'(32'(rr_ptr) + k - NUM_SRC);
      else                            cand = GW'(32'(rr_ptr) + k);
      if (!pick_vld && src_ready[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // One-hot completion pulse; a watchdog grant matches no source.
  always_comb begin
    ack_vec = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) ack_vec[i] = (grant_id == GW'(i));
  end

  always_comb begin
    state_n       = state;
    tcnt_n        = tcnt;
    wcnt_n        = wcnt;
    wdog_pend_n   = wdog_pend;
    rr_ptr_n      = rr_ptr;
    grant_id_n    = grant_id;
    ctl_command_n = ctl_command;
    ctl_ready_n   = ctl_ready;
    src_ack_n     = '0;
    timeout_err_n = 1'b0;
    wdog_fired_n  = 1'b0;

    if (WDOG_EN && (state == S_IDLE) && !(|src_ready) && !wdog_pend) begin
      if (wdog_hit) begin
        wdog_pend_n = 1'b1;
        wcnt_n      = '0;
      end else begin
        wcnt_n = wcnt + WW'(1);
      end
    end

    case (state)
      S_IDLE: begin
        if (wdog_pend) begin
          grant_id_n    = GW'(NUM_SRC);
          ctl_command_n = STOP_CMD;
          wdog_fired_n  = 1'b1;
          wdog_pend_n   = 1'b0;
          state_n       = S_ISSUE;
        end else if (pick_vld) begin
          grant_id_n    = pick_idx;
          ctl_command_n = src_cmd_a[pick_idx];
          rr_ptr_n      = pick_idx;
          state_n       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ctl_ready_n = 1'b1;
        tcnt_n      = '0;
        state_n     = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (ack_s) begin
          ctl_ready_n = 1'b0;
          tcnt_n      = '0;
          state_n     = S_WAIT_LO;
        end else if (tmo_hit) begin
          ctl_ready_n   = 1'b0;
          timeout_err_n = 1'b1;
          state_n       = S_IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      // Command already accepted here, so a stuck-high ack still completes.
      S_WAIT_LO: begin
        if (!ack_s) begin
          src_ack_n = ack_vec;
          state_n   = S_DONE;
        end else if (tmo_hit) begin
          timeout_err_n = 1'b1;
          src_ack_n     = ack_vec;
          state_n       = S_DONE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      S_DONE: begin
        wcnt_n  = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      wcnt        <= '0;
      wdog_pend   <= 1'b0;
      rr_ptr      <= GW'(NUM_SRC - 1);
      grant_id    <= '0;
      ctl_command <= '0;
      ctl_ready   <= 1'b0;
      src_ack     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wdog_fired  <= 1'b0;
    end else begin
      state       <= state_n;
      tcnt        <= tcnt_n;
      wcnt        <= wcnt_n;
      wdog_pend   <= wdog_pend_n;
      rr_ptr      <= rr_ptr_n;
      grant_id    <= grant_id_n;
      ctl_command <= ctl_command_n;
      ctl_ready   <= ctl_ready_n;
      src_ack     <= src_ack_n;
      busy        <= (state_n != S_IDLE);
      timeout_err <= timeout_err_n;
      wdog_fired  <= wdog_fired_n;
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter with a sclk-paced control-block ack model.
`timescale 1ns/1ps
module tb_cmd_arbiter;

  localparam int unsigned NS   = 3;
  localparam logic [31:0] STOP = 32'h619EFF00;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NS-1:0]     src_ready;
  logic [32*NS-1:0]  src_command;
  logic [NS-1:0]     src_ack;
  logic              ctl_ready;
  logic [31:0]       ctl_command;
  logic              ctl_ack = 1'b0;
  logic [1:0]        grant_id;
  logic              busy, timeout_err, wdog_fired;

  cmd_arbiter #(
    .clk_hz(1000), .sclk_hz(100), .NUM_SRC(NS),
    .TIMEOUT_SCLK(4), .WDOG_MS(200), .STOP_CMD(STOP)
  ) dut (
    .clk(clk), .rst(rst), .src_ready(src_ready), .src_command(src_command),
    .src_ack(src_ack), .ctl_ready(ctl_ready), .ctl_command(ctl_command),
    .ctl_ack(ctl_ack), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .wdog_fired(wdog_fired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Sources: pending while issued requests exceed completed ones.
  int          req_cnt  [NS] = '{0, 0, 0};
  int          done_cnt [NS] = '{0, 0, 0};
  logic [31:0] cmd_base [NS] = '{32'h0, 32'h0, 32'h0};

  assign src_ready   = {req_cnt[2] != done_cnt[2], req_cnt[1] != done_cnt[1], req_cnt[0] != done_cnt[0]};
  assign src_command = {cmd_base[2] + 32'(done_cnt[2]), cmd_base[1] + 32'(done_cnt[1]),
                        cmd_base[0] + 32'(done_cnt[0])};

  task automatic request(input int i, input int count, input logic [31:0] cmd);
    cmd_base[i] = cmd - 32'(done_cnt[i]);
    req_cnt[i]  = done_cnt[i] + count;
  endtask

  initial begin : src_model
    logic [NS-1:0] a;
    forever begin
      @(negedge clk);
      a = src_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) if (a[i]) done_cnt[i]++;
    end
  end

  // Control block: acts once per sclk period (10 clk).
  logic ack_en = 1'b1;
  initial begin : ack_model
    int sdiv = 0;
    forever begin
      @(posedge clk);
      #1;
      sdiv++;
      if (sdiv == 10) begin
        sdiv = 0;
        if (ctl_ready && ack_en) ctl_ack = 1'b1;
        else if (!ctl_ready)     ctl_ack = 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [1:0]  gid;
    logic [31:0] cmd;
  } exp_t;

  exp_t          exp_q [$];
  logic [NS-1:0] ack_q [$];

  task automatic expect_grant(input logic [1:0] gid, input logic [31:0] cmd);
    exp_q.push_back('{gid: gid, cmd: cmd});
  endtask

  int   hi_len = 0;
  int   last_hi_len = 0;
  int   to_cnt = 0;
  int   wd_cnt = 0;

  initial begin : monitor
    exp_t e;
    logic prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ctl_ready && !prev_ready) begin
          if (exp_q.size() == 0) check("grant_unexp", 32'(exp_q.size()), 32'd1);
          else begin
            e = exp_q.pop_front();
            check("grant_id", 32'(grant_id), 32'(e.gid));
            check("grant_cmd", ctl_command, e.cmd);
          end
        end
        if (src_ack != '0) begin
          if (ack_q.size() == 0) check("ack_unexp", 32'(src_ack), 32'd0);
          else                   check("src_ack", 32'(src_ack), 32'(ack_q.pop_front()));
        end
        if (timeout_err) to_cnt++;
        if (wdog_fired)  wd_cnt++;
      end
      if (ctl_ready) hi_len++;
      else if (hi_len != 0) begin
        last_hi_len = hi_len;
        hi_len      = 0;
      end
      prev_ready = ctl_ready;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NS; i++) req_cnt[i] = done_cnt[i];
    repeat (15) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ack_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_complete"}, 32'(n < 2000), 32'd1);
  endtask

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int n;
    int base;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ctl_ready), 32'd0);
    check("rst_cmd", ctl_command, 32'd0);
    check("rst_ack", 32'(src_ack), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_to", 32'(timeout_err), 32'd0);
    check("rst_wd", 32'(wdog_fired), 32'd0);
    rst = 1'b0;

    // Single request
    expect_grant(2'd0, 32'h7C83FF00);
    ack_q.push_back(3'b001);
    request(0, 1, 32'h7C83FF00);
    n = 0;
    do begin @(negedge clk); n++; end while (!ctl_ready && n < 50);
    check("t1_latency", 32'(n), 32'd2);
    n = 0;
    do begin @(negedge clk); n++; end while (!src_ack[0] && n < 200);
    check("t1_ack_seen", 32'(src_ack[0]), 32'd1);
    @(negedge clk);
    check("t1_ack_pulse", 32'(src_ack), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    wait_done("t1");

    // Simultaneous requests, round-robin 0,1,2,0
    do_reset();
    expect_grant(2'd0, 32'h11EE0100);
    expect_grant(2'd1, 32'h22DD0200);
    expect_grant(2'd2, 32'h33CC0300);
    expect_grant(2'd0, 32'h11EE0101);
    ack_q.push_back(3'b001);
    ack_q.push_back(3'b010);
    ack_q.push_back(3'b100);
    ack_q.push_back(3'b001);
    request(0, 2, 32'h11EE0100);
    request(1, 1, 32'h22DD0200);
    request(2, 1, 32'h33CC0300);
    wait_done("t2");

    // Handshake timeout with ack suppressed
    do_reset();
    base   = to_cnt;
    ack_en = 1'b0;
    expect_grant(2'd0, 32'hA5A50F00);
    expect_grant(2'd1, 32'h5A5AF000);
    expect_grant(2'd0, 32'hA5A50F00);
    ack_q.push_back(3'b010);
    ack_q.push_back(3'b001);
    request(0, 1, 32'hA5A50F00);
    request(1, 1, 32'h5A5AF000);
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout_err && n < 200);
    check("t3_to_seen", 32'(timeout_err), 32'd1);
    check("t3_ready_low", 32'(ctl_ready), 32'd0);
    ack_en = 1'b1;
    @(negedge clk);
    check("t3_to_pulse", 32'(timeout_err), 32'd0);
    check("t3_hi_len", 32'(last_hi_len), 32'd40);
    wait_done("t3");
    check("t3_to_cnt", 32'(to_cnt - base), 32'd1);

    // Watchdog, with a request landing in the same IDLE cycle
    do_reset();
    base = wd_cnt;
    expect_grant(2'd3, STOP);
    expect_grant(2'd0, 32'h40BFFF00);
    ack_q.push_back(3'b001);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 200) request(0, 1, 32'h40BFFF00);
    end while (!wdog_fired && n < 400);
    check("t4_wdog_time", 32'(n), 32'd201);
    check("t4_gid", 32'(grant_id), 32'd3);
    check("t4_cmd", ctl_command, STOP);
    wait_done("t4");
    check("t4_wd_cnt", 32'(wd_cnt - base), 32'd1);

    // Reset during WAIT_LO
    do_reset();
    expect_grant(2'd1, 32'h6699AA00);
    request(1, 1, 32'h6699AA00);
    n = 0;
    do begin @(negedge clk); n++; end while (!ctl_ready && n < 100);
    do begin @(negedge clk); n++; end while (ctl_ready && n < 200);
    check("t5_pre_busy", 32'(busy), 32'd1);
    check("t5_pre_gid", 32'(grant_id), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", 32'(ctl_ready), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_gid", 32'(grant_id), 32'd0);
    check("t5_rst_cmd", ctl_command, 32'd0);
    request(0, 1, 32'h0CF3FF00);
    expect_grant(2'd0, 32'h0CF3FF00);
    expect_grant(2'd1, 32'h6699AA00);
    ack_q.push_back(3'b001);
    ack_q.push_back(3'b010);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    wait_done("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
Shares the single command/ready/ack handshake of the cart control block between several command sources: IR decoder, UART link and autonomous planner.
- Round-robin arbitration between real sources.
- Holds each grant until the control block has acknowledged the command and dropped its ack.
- Times out a stalled handshake.
- Safety watchdog: injects a motor-stop command when no command has completed for a configurable time.
- Sits between the source decoders and the control block's ir_ready/command/ack pins.

Parameters:
- clk_hz, 25000000, system clock frequency.
- sclk_hz, 256, control block sampling clock; used for timeout sizing.
- NUM_SRC, 3, number of real command sources.
- TIMEOUT_SCLK, 4, handshake timeout in sclk periods; TIMEOUT_CYC = TIMEOUT_SCLK*clk_hz/sclk_hz.
- WDOG_MS, 500, idle time before stop injection; WDOG_CYC = clk_hz/1000*WDOG_MS; 0 disables the watchdog.
- STOP_CMD, 32'h619EFF00, command injected by the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- src_ready  in  NUM_SRC  per-source command valid; level, held until src_ack.
- src_command  in  32*NUM_SRC  packed commands; source i occupies bits [32*i+31:32*i].
- src_ack  out  NUM_SRC  one-clk pulse to the completed source.
- ctl_ready  out  1  to control ir_ready.
- ctl_command  out  32  to control command.
- ctl_ack  in  1  from control ack; generated in the sclk domain.
- grant_id  out  $clog2(NUM_SRC+1)  current owner; value NUM_SRC = watchdog.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  one-clk pulse on handshake timeout.
- wdog_fired  out  1  one-clk pulse when a stop command is injected.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- ctl_ack synchroniser: 2-flop synchroniser to clk; all ack references below use the synchronised value ack_s.
- Reset values:
  - ctl_ready=0, ctl_command=0, src_ack=0, grant_id=0, busy=0, timeout_err=0, wdog_fired=0.
  - rr_ptr=NUM_SRC-1, so source 0 wins first.
  - Timeout and watchdog counters = 0; state = IDLE.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - If wdog_pend, grant the watchdog: grant_id=NUM_SRC, ctl_command=STOP_CMD, wdog_fired pulses, wdog_pend clears.
  - Else, if any src_ready, grant the first set bit searching rr_ptr+1 upward with wrap. Latch its command into ctl_command and set rr_ptr to the granted index.
  - Either grant moves to ISSUE the next cycle.
- ISSUE: ctl_ready=1; go to WAIT_HI; clear the timeout counter.
- WAIT_HI:
  - On ack_s=1: ctl_ready=0; go to WAIT_LO; clear the timeout counter.
  - If the counter reaches TIMEOUT_CYC-1: ctl_ready=0, timeout_err pulse, back to IDLE, no src_ack. The source stays pending and competes again; rr_ptr has already advanced past it.
- WAIT_LO:
  - On ack_s=0: go to DONE.
  - On timeout: timeout_err pulse and go to DONE anyway, since the command was accepted.
- DONE:
  - src_ack[grant_id] pulses for exactly one clk; no pulse for a watchdog grant.
  - Clear the watchdog counter; back to IDLE.
- Source rule: a source drops src_ready on the edge after its src_ack. The arbiter does not sample src_ready in DONE.
- Latency: a request in IDLE reaches ctl_ready=1 two clks later. A source withdrawing src_ready mid-grant is ignored; the latched command is still delivered.
- ctl_command is held stable from grant until DONE.
- Watchdog:
  - Counts clk while state==IDLE and no src_ready is set; any DONE clears it.
  - At WDOG_CYC-1 it sets wdog_pend and clears the count.
  - If wdog_pend and a src_ready are set together in IDLE, the watchdog wins.
- Simultaneous requests: exactly one grant per IDLE cycle; round-robin gives no source two consecutive grants while others are pending.
- Reset mid-operation: everything returns to reset values immediately. ctl_ready drops asynchronously; no src_ack is issued.
- Counter widths: $clog2 of the respective max; no wrap occurs because counters clear on state change.

Decomposition:
- cart_pkg: command code constants (CMD_ON, CMD_OFF, CMD_STOP=32'h619EFF00, CMD_FWD, CMD_REV, speed/steer codes) and the arb_state_t enum.
- Sub-module sync_2ff: parameterised width, async active-high reset to 0; used for ctl_ack.

Test Plan:
Bench parameters: clk_hz=1000, sclk_hz=100, TIMEOUT_SCLK=4 (TIMEOUT_CYC=40), WDOG_MS=200 (WDOG_CYC=200); ack modelled as control does, per sclk edge.
- Single request: src_ready=3'b001, command 32'h7C83FF00.
  -> ctl_ready high 2 clks later with ctl_command=32'h7C83FF00, grant_id=0.
  -> src_ack[0] single pulse after ack rises then falls; busy low afterwards.
- All three sources request simultaneously and hold.
  -> grants in order 0,1,2,0.
  -> each src_ack pulses once; ctl_command matches the granted source.
- Ack never asserted.
  -> ctl_ready drops after 40 clks in WAIT_HI; timeout_err pulses once; no src_ack.
  -> the next grant goes to the next pending source.
- No requests for 200 clks after reset.
  -> wdog_fired pulse; grant_id=3; ctl_command=32'h619EFF00; no src_ack.
  -> a request in the same IDLE cycle is served after the watchdog handshake.
- rst asserted during WAIT_LO.
  -> ctl_ready, busy, grant_id, ctl_command = 0 immediately.
  -> no src_ack; after release, a pending source 0 is granted first.
